// File: rtl/ma_feeder_pkg.sv
// Shared types and sizing helpers for the MA operand feeder.
package ma_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KERN,
    LOAD_WIN,
    START,
    WAIT,
    OUTPUT,
    FLUSH
  } state_t;

  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_CHANNELS    = 1;

  // Index width for a counter covering 0..n-1, never narrower than 1 bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ma_feeder_if.sv
// Word-stream and result-beat handshakes between the data movers and ma_feeder.
interface ma_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 1
);

  logic [DATA_WIDTH-1:0]  s_kern_data;
  logic                   s_kern_valid;
  logic                   s_kern_ready;
  logic [DATA_WIDTH-1:0]  s_pix_data;
  logic                   s_pix_valid;
  logic                   s_pix_ready;
  logic [CHANNELS*32-1:0] m_res_data;
  logic                   m_res_valid;
  logic                   m_res_ready;

  modport master (
    output s_kern_data, s_kern_valid, input s_kern_ready,
    output s_pix_data,  s_pix_valid,  input s_pix_ready,
    input  m_res_data,  m_res_valid,  output m_res_ready
  );

  modport slave (
    input  s_kern_data, s_kern_valid, output s_kern_ready,
    input  s_pix_data,  s_pix_valid,  output s_pix_ready,
    output m_res_data,  m_res_valid,  input  m_res_ready
  );

endinterface

// File: rtl/ma_feeder_loader.sv
// Word counter plus shift-in operand register; first accepted word ends up in slot 0.
module ma_feeder_loader
  import ma_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        valid,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic [WORDS*DATA_WIDTH-1:0] operands,
  output logic                        last
);

  localparam int CNT_W = idx_w(WORDS);

  logic [CNT_W-1:0]                  cnt;
  logic [WORDS-1:0][DATA_WIDTH-1:0]  words;
  logic                              take;

  assign take     = en && valid;
  assign last     = take && (cnt == CNT_W'(WORDS-1));
  assign operands = words;

  // Shifting toward slot 0 avoids a per-word write decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      words <= '0;
    end else if (take) begin
      cnt <= last ? '0 : cnt + 1'b1;
      for (int i = 0; i < WORDS-1; i++) words[i] <= words[i+1];
      words[WORDS-1] <= data;
    end
  end

endmodule

// File: rtl/ma_feeder.sv
// MA initiator: loads kernel/window operands, pulses mstart, gathers per-channel sums.
// Optional WAIT watchdog with MA flush enabled by `define MA_FEEDER_TIMEOUT_EN.
module ma_feeder
  import ma_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int TAPS           = KERNEL_SIZE*KERNEL_SIZE,
  parameter int WORDS          = CHANNELS*TAPS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ma_feeder_if.slave                  bus,
  output logic [WORDS*DATA_WIDTH-1:0] multiplier_o,
  output logic [WORDS*DATA_WIDTH-1:0] multiplicand_o,
  output logic [TAPS-1:0]             mstart_o,
  output logic                        ma_rst_o,
  input  logic [CHANNELS*32-1:0]      final_accumulate_i,
  input  logic [CHANNELS-1:0]         final_ready_i,
  output logic                        kernel_valid_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  state_t                    state, state_nx;
  logic                      kern_en, pix_en, kern_last, pix_last, res_valid;
  logic                      all_done, wd_expire, flush_done;
  logic [CHANNELS-1:0]       mask;
  logic [CHANNELS-1:0][31:0] res_q;

  // Count this cycle's strobes so the last ready moves to OUTPUT without a bubble.
  assign all_done = &(mask | final_ready_i);

  ma_feeder_loader #(.DATA_WIDTH(DATA_WIDTH), .WORDS(WORDS)) u_kern (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (kern_en),
    .valid    (bus.s_kern_valid),
    .data     (bus.s_kern_data),
    .operands (multiplier_o),
    .last     (kern_last)
  );

  ma_feeder_loader #(.DATA_WIDTH(DATA_WIDTH), .WORDS(WORDS)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pix_en),
    .valid    (bus.s_pix_valid),
    .data     (bus.s_pix_data),
    .operands (multiplicand_o),
    .last     (pix_last)
  );

`ifdef MA_FEEDER_TIMEOUT_EN
  localparam int WD_W = idx_w(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wdog;
  logic            flush_cnt, timeout_q;

  assign wd_expire  = (wdog == WD_W'(TIMEOUT_CYCLES-1));
  assign flush_done = flush_cnt;
  assign timeout_o  = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      flush_cnt <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == START)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      // Second FLUSH cycle is marked so ma_rst_o spans exactly two cycles.
      flush_cnt <= (state == FLUSH) && !flush_cnt;
      if (state == WAIT && state_nx == FLUSH) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire  = 1'b0;
  assign flush_done = 1'b1;
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    kern_en   = 1'b0;
    pix_en    = 1'b0;
    res_valid = 1'b0;
    ma_rst_o  = 1'b0;
    mstart_o  = '0;
    case (state)
      IDLE: begin
        if (bus.s_kern_valid)                        state_nx = LOAD_KERN;
        else if (bus.s_pix_valid && kernel_valid_o)  state_nx = LOAD_WIN;
      end
      LOAD_KERN: begin
        kern_en = 1'b1;
        if (kern_last) state_nx = IDLE;
      end
      LOAD_WIN: begin
        pix_en = 1'b1;
        if (pix_last) state_nx = START;
      end
      START: begin
        mstart_o = '1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (all_done)       state_nx = OUTPUT;
        else if (wd_expire) state_nx = FLUSH;
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (bus.m_res_ready) state_nx = IDLE;
      end
      FLUSH: begin
`ifdef MA_FEEDER_TIMEOUT_EN
        ma_rst_o = 1'b1;
`endif
        if (flush_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Kernel is invalidated as soon as a reload starts; it survives flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                kernel_valid_o <= 1'b0;
    else if (state == IDLE && bus.s_kern_valid) kernel_valid_o <= 1'b0;
    else if (state == LOAD_KERN && kern_last)   kernel_valid_o <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      res_q <= '0;
    end else if (state == START) begin
      mask <= '0;
    end else if (state == WAIT) begin
      mask <= mask | final_ready_i;
      for (int c = 0; c < CHANNELS; c++)
        if (final_ready_i[c]) res_q[c] <= final_accumulate_i[c*32 +: 32];
    end
  end

  assign busy_o           = (state != IDLE);
  assign bus.s_kern_ready = kern_en;
  assign bus.s_pix_ready  = pix_en;
  assign bus.m_res_valid  = res_valid;
  assign bus.m_res_data   = res_q;

endmodule

// File: tb/tb_ma_feeder.sv
// Scoreboard bench for ma_feeder: one 1-channel and one 2-channel instance with MA models.
`timescale 1ns/1ps
module tb_ma_feeder;

  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ma_feeder_if #(.DATA_WIDTH(32), .CHANNELS(1)) b0();
  ma_feeder_if #(.DATA_WIDTH(32), .CHANNELS(2)) b1();

  logic [9*32-1:0]  mul0, mc0;
  logic [18*32-1:0] mul1, mc1;
  logic [8:0]       ms0, ms1;
  logic             mr0, kv0, bz0, to0, mr1, kv1, bz1, to1;
  logic [31:0]      fa0;
  logic             fr0;
  logic [63:0]      fa1;
  logic [1:0]       fr1;

  ma_feeder #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(1), .TIMEOUT_CYCLES(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .multiplier_o(mul0), .multiplicand_o(mc0), .mstart_o(ms0), .ma_rst_o(mr0),
    .final_accumulate_i(fa0), .final_ready_i(fr0),
    .kernel_valid_o(kv0), .busy_o(bz0), .timeout_o(to0)
  );

  ma_feeder #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(2), .TIMEOUT_CYCLES(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .multiplier_o(mul1), .multiplicand_o(mc1), .mstart_o(ms1), .ma_rst_o(mr1),
    .final_accumulate_i(fa1), .final_ready_i(fr1),
    .kernel_valid_o(kv1), .busy_o(bz1), .timeout_o(to1)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [63:0] sb0[$];
  logic [63:0] sb1[$];
  bit mute0 = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic wq_t fill(int n, logic [31:0] base, logic [31:0] inc);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(base + inc*32'(i));
    return q;
  endfunction

  task automatic drv(int sel, bit kern, bit v, logic [31:0] d);
    if (sel == 0) begin
      if (kern) begin b0.s_kern_valid = v; b0.s_kern_data = d; end
      else      begin b0.s_pix_valid  = v; b0.s_pix_data  = d; end
    end else begin
      if (kern) begin b1.s_kern_valid = v; b1.s_kern_data = d; end
      else      begin b1.s_pix_valid  = v; b1.s_pix_data  = d; end
    end
  endtask

  function automatic bit rdy(int sel, bit kern);
    if (sel == 0) return kern ? b0.s_kern_ready : b0.s_pix_ready;
    return kern ? b1.s_kern_ready : b1.s_pix_ready;
  endfunction

  function automatic bit vld(int sel);
    return (sel == 0) ? b0.m_res_valid : b1.m_res_valid;
  endfunction

  // Sends each word with a bounded wait for ready; returns at posedge+1 after the last transfer.
  task automatic send(int sel, bit kern, input wq_t w);
    foreach (w[i]) begin
      int t;
      t = 0;
      drv(sel, kern, 1'b1, w[i]);
      @(negedge clk);
      while (!rdy(sel, kern) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
        n_chk++;
        $display("FAIL xfer_wait: sel %0d kern %0d word %0d not accepted in %0d cycles", sel, kern, i, t);
        drv(sel, kern, 1'b0, '0);
        return;
      end
      @(posedge clk); #1;
    end
    drv(sel, kern, 1'b0, '0);
  endtask

  task automatic wait_valid(int sel, int exp, string nm);
    int t;
    t = 0;
    while (!vld(sel) && t < 100) begin step(); t++; end
    chk(nm, t, exp);
  endtask

  // MA model, 1 channel: sum of products 5 cycles after mstart.
  int cd0;
  logic [31:0] acc0;
  initial begin
    fr0 = 1'b0; fa0 = '0; cd0 = 0; acc0 = '0;
    forever begin
      @(posedge clk); #1;
      fr0 = 1'b0;
      if (cd0 > 0) begin
        cd0--;
        if (cd0 == 0) begin fr0 = 1'b1; fa0 = acc0; end
      end
      if (ms0 != 0 && !mute0) begin
        cd0 = 5; acc0 = '0;
        for (int w = 0; w < 9; w++) acc0 += mul0[w*32 +: 32] * mc0[w*32 +: 32];
      end
    end
  end

  // MA model, 2 channels: channel 0 strobes at +3, channel 1 at +7.
  int el1;
  logic [31:0] s0_1, s1_1;
  initial begin
    fr1 = '0; fa1 = '0; el1 = -1; s0_1 = '0; s1_1 = '0;
    forever begin
      @(posedge clk); #1;
      fr1 = '0;
      if (el1 >= 0) begin
        el1++;
        if (el1 == 3) begin fr1[0] = 1'b1; fa1[31:0] = s0_1; end
        if (el1 == 7) begin fr1[1] = 1'b1; fa1[63:32] = s1_1; el1 = -1; end
      end
      if (ms1 != 0) begin
        el1 = 0; s0_1 = '0; s1_1 = '0;
        for (int w = 0; w < 9; w++) begin
          s0_1 += mul1[w*32 +: 32] * mc1[w*32 +: 32];
          s1_1 += mul1[(w+9)*32 +: 32] * mc1[(w+9)*32 +: 32];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && b0.m_res_valid && b0.m_res_ready) begin
        if (sb0.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat0: data %0h, no result expected", b0.m_res_data);
        end else chk("res0", 64'(b0.m_res_data), sb0.pop_front());
      end
      if (rst_n && b1.m_res_valid && b1.m_res_ready) begin
        if (sb1.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat1: data %0h, no result expected", b1.m_res_data);
        end else chk("res1", 64'(b1.m_res_data), sb1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wq_t q;
    bit seen;
    int hi;
    drv(0, 1'b1, 1'b0, '0); drv(0, 1'b0, 1'b0, '0);
    drv(1, 1'b1, 1'b0, '0); drv(1, 1'b0, 1'b0, '0);
    b0.m_res_ready = 1'b1; b1.m_res_ready = 1'b1;

    @(negedge clk);
    chk("rst_mul", 64'(mul0 != 0), 0);
    chk("rst_mcand", 64'(mc0 != 0), 0);
    chk("rst_mstart", ms0, 0);
    chk("rst_ma_rst", mr0, 0);
    chk("rst_res_data", b0.m_res_data, 0);
    chk("rst_res_valid", b0.m_res_valid, 0);
    chk("rst_kv", kv0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_timeout", to0, 0);
    chk("rst_kern_ready", b0.s_kern_ready, 0);
    chk("rst_pix_ready", b0.s_pix_ready, 0);
    chk("rst_u1", {kv1, bz1, to1, mr1, b1.m_res_valid}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(2);

    // Pixels with no kernel must wait, then a 2,0,..,0 kernel gives 2.
    drv(0, 1'b0, 1'b1, 32'd1);
    seen = 1'b0;
    repeat (10) begin step(); if (b0.s_pix_ready || ms0 != 0) seen = 1'b1; end
    chk("no_pix_without_kernel", seen, 0);
    q = fill(9, 0, 0); q[0] = 32'd2;
    send(0, 1'b1, q);
    chk("kv_after_load", kv0, 1);
    chk("mul_word0", mul0[31:0], 2);
    sb0.push_back(64'd2);
    send(0, 1'b0, fill(9, 1, 1));
    chk("mstart_a", ms0, 9'h1FF);
    wait_valid(0, 6, "lat_a");
    step();

    // Ones kernel, window 1..9 -> 45.
    send(0, 1'b1, fill(9, 1, 0));
    sb0.push_back(64'd45);
    send(0, 1'b0, fill(9, 1, 1));
    chk("mstart_b", ms0, 9'h1FF);
    chk("mcand_top", mc0[8*32 +: 32], 9);
    wait_valid(0, 6, "lat_b");
    step();

    // Result back-pressure: window of 3s -> 27 held for 20 cycles.
    b0.m_res_ready = 1'b0;
    sb0.push_back(64'd27);
    send(0, 1'b0, fill(9, 3, 0));
    wait_valid(0, 6, "lat_c");
    drv(0, 1'b0, 1'b1, 32'd5);
    repeat (20) begin
      step();
      chk("hold_valid", b0.m_res_valid, 1);
      chk("hold_data", b0.m_res_data, 27);
      chk("hold_pix_ready", b0.s_pix_ready, 0);
    end
    b0.m_res_ready = 1'b1;
    step();
    drv(0, 1'b0, 1'b0, '0);
    chk("drop_valid", b0.m_res_valid, 0);
    chk("back_idle", bz0, 0);
    step();

    // Two channels: kernel 1s / 2s, window 1..9 each -> {90, 45} at +8.
    q = fill(9, 1, 0);
    for (int i = 0; i < 9; i++) q.push_back(32'd2);
    send(1, 1'b1, q);
    q = fill(9, 1, 1);
    for (int i = 0; i < 9; i++) q.push_back(32'(i + 1));
    sb1.push_back({32'd90, 32'd45});
    send(1, 1'b0, q);
    chk("mstart_d", ms1, 9'h1FF);
    wait_valid(1, 8, "lat_d");
    step();

    // MA never answers.
    mute0 = 1'b1;
    send(0, 1'b0, fill(9, 1, 1));
`ifdef MA_FEEDER_TIMEOUT_EN
    hi = 0;
    while (!mr0 && hi < 100) begin step(); hi++; end
    chk("flush_lat", hi, 17);
    step();
    chk("ma_rst_cycle2", mr0, 1);
    step();
    chk("ma_rst_end", mr0, 0);
    chk("timeout_set", to0, 1);
    chk("flush_idle", bz0, 0);
    chk("flush_kv", kv0, 1);
    mute0 = 1'b0;
    sb0.push_back(64'd45);
    send(0, 1'b0, fill(9, 1, 1));
    wait_valid(0, 6, "lat_e");
    step();
    chk("timeout_sticky", to0, 1);
`else
    hi = 0;
    repeat (40) begin step(); if (mr0) hi++; end
    chk("no_flush", hi, 0);
    chk("wait_forever", bz0, 1);
    chk("timeout_tied", to0, 0);
    mute0 = 1'b0;
`endif

    // Reset during LOAD_WIN after 4 words.
    rst_n = 1'b0; step(2); rst_n = 1'b1; step();
    send(0, 1'b1, fill(9, 1, 0));
    send(0, 1'b0, fill(4, 1, 1));
    chk("partial_loaded", 64'(mc0 != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mcand", 64'(mc0 != 0), 0);
    chk("rst_mid_mul", 64'(mul0 != 0), 0);
    chk("rst_mid_kv", kv0, 0);
    chk("rst_mid_busy", bz0, 0);
    chk("rst_mid_pix_ready", b0.s_pix_ready, 0);
    step(2);
    rst_n = 1'b1;
    drv(0, 1'b0, 1'b1, 32'd1);
    seen = 1'b0;
    repeat (10) begin step(); if (b0.s_pix_ready || ms0 != 0) seen = 1'b1; end
    chk("no_pix_after_rst", seen, 0);
    send(0, 1'b1, fill(9, 1, 0));
    sb0.push_back(64'd45);
    send(0, 1'b0, fill(9, 1, 1));
    chk("mstart_f", ms0, 9'h1FF);
    wait_valid(0, 6, "lat_f");
    step(5);

    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ma_feeder.md
Name: ma_feeder

Overview:
- Initiator side of the matrix-accelerator (MA) multiply/accumulate interface.
- Accepts kernel coefficients and pixel windows as valid/ready word streams and packs them onto the flat multiplier/multiplicand buses.
- Pulses the start vector, collects per-channel accumulations on their ready strobes, and emits one result beat per window.
- Sits between the PS-side data movers and the MA core; replaces BD-driven start/operand logic.

Parameters:
- DATA_WIDTH, 32, operand word width.
- KERNEL_SIZE, 3, kernel edge length.
- CHANNELS, 1, parallel channels.
- TAPS, KERNEL_SIZE*KERNEL_SIZE, taps per channel (derived).
- WORDS, CHANNELS*TAPS, words per kernel or window load (derived).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_kern_data  in  DATA_WIDTH  kernel coefficient word
- s_kern_valid  in  1  kernel word valid
- s_kern_ready  out  1  kernel word accepted
- s_pix_data  in  DATA_WIDTH  window pixel word
- s_pix_valid  in  1  pixel word valid
- s_pix_ready  out  1  pixel word accepted
- multiplier_o  out  WORDS*DATA_WIDTH  kernel bus to MA
- multiplicand_o  out  WORDS*DATA_WIDTH  window bus to MA
- mstart_o  out  TAPS  per-tap multiply start
- ma_rst_o  out  1  active-high MA flush
- final_accumulate_i  in  CHANNELS*32  per-channel sums
- final_ready_i  in  CHANNELS  per-channel sum valid
- m_res_data  out  CHANNELS*32  captured sums
- m_res_valid  out  1  result valid
- m_res_ready  in  1  result accepted
- kernel_valid_o  out  1  complete kernel held
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async): state=IDLE. All outputs and registers are 0, including operand buses, mstart_o, ma_rst_o, m_res_*, kernel_valid_o, timeout_o and counters.
- Word order: channel-major, then tap ascending. Word n=c*TAPS+t lands in bits [n*DATA_WIDTH +: DATA_WIDTH] of the respective bus.
- Transfers occur only on valid&&ready. s_kern_ready is high only in LOAD_KERN; s_pix_ready only in LOAD_WIN.
- IDLE:
  - s_kern_valid -> LOAD_KERN; clear kernel_valid_o on entry. Kernel takes priority over pixels.
  - else s_pix_valid && kernel_valid_o -> LOAD_WIN.
  - Pixels with no kernel loaded wait; they are not dropped.
- LOAD_KERN: accept WORDS words into multiplier_o. Next cycle after the last word: set kernel_valid_o, -> IDLE.
- LOAD_WIN: accept WORDS words into multiplicand_o. After the last word -> START. The kernel persists across windows.
- START: mstart_o = all ones for exactly 1 cycle. Clear the capture mask and the watchdog counter. -> WAIT.
- WAIT:
  - On any cycle where final_ready_i[c]=1, capture final_accumulate_i[c] into m_res_data[c] and set mask[c].
  - Repeated strobes overwrite the captured value.
  - When the mask is all ones -> OUTPUT; m_res_valid rises the next cycle.
- OUTPUT: m_res_valid=1 with m_res_data stable until m_res_ready. The handshake cycle drops valid and returns to IDLE. A new window is accepted no earlier than the cycle after.
- Latency: last window word -> mstart pulse is 1 cycle. Final channel ready -> m_res_valid is 1 cycle.
- Operand buses hold their values outside load states. Partial loads are interrupted only by reset.
- final_ready_i outside WAIT is ignored.

Optional Feature:
- Macro: MA_FEEDER_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles. Reaching TIMEOUT_CYCLES-1 without a full mask -> FLUSH.
  - FLUSH: ma_rst_o=1 for 2 cycles, set timeout_o (sticky until rst_n), discard the partial result (no m_res beat), -> IDLE.
  - kernel_valid_o is retained.
- Undefined: WAIT waits indefinitely; ma_rst_o and timeout_o are tied 0; no counter is synthesised.

Decomposition:
- Package ma_feeder_pkg: state enum (IDLE, LOAD_KERN, LOAD_WIN, START, WAIT, OUTPUT, FLUSH) and the WORDS/TAPS index-width localparams.
- One natural sub-module, ma_feeder_loader: a counter plus a bus-shift writer. Instantiate it twice, once for kernel and once for window.

Test Plan (KERNEL_SIZE=3, CHANNELS=1, MA model returns sum of products 5 cycles after mstart):
- Kernel of nine 1s, window 1..9 -> mstart_o=9'h1FF one cycle after the 9th pixel; m_res_data=45, m_res_valid 6 cycles after mstart.
- Pixels presented before any kernel -> s_pix_ready stays 0 and no mstart. Then load kernel 2,0,...,0 -> result 2 for window 1..9.
- m_res_ready held low for 20 cycles -> m_res_valid and data stay constant, s_pix_ready stays 0. Ready high for 1 cycle -> IDLE.
- CHANNELS=2, ready strobes on channel 0 at +3 and channel 1 at +7 -> a single beat at +8 carrying both sums.
- MA model never asserts ready, with MA_FEEDER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16 -> ma_rst_o high 2 cycles, timeout_o=1, no result beat, next window completes normally.
- rst_n low mid-LOAD_WIN (after 4 words) -> all outputs 0 immediately and kernel_valid_o=0. After release, a kernel reload is required before any window is accepted.
